// File: rtl/debounce_pkg.sv
// -----------------------------------------------------------------------------
// debounce_pkg
// Shared constants and helpers for the button conditioner (debounce_multi).
//   cnt_width()          : counter width for a terminal value, never below 1 bit
//   DEF_*_CYCLES         : reference timings for a 100 MHz board clock
// -----------------------------------------------------------------------------
package debounce_pkg;

   localparam int CLK_HZ            = 100_000_000;
   localparam int DEF_STABLE_CYCLES = CLK_HZ / 100;   // 10 ms
   localparam int DEF_LONG_CYCLES   = CLK_HZ / 2;     // 0.5 s
   localparam int DEF_REPEAT_CYCLES = CLK_HZ / 10;    // 0.1 s

   // $clog2 of 0 or 1 gives a zero-width counter; clamp to 2 first.
   function automatic int cnt_width(input int v);
      return $clog2((v < 2) ? 2 : v);
   endfunction

endpackage

// File: rtl/debounce_chan.sv
// -----------------------------------------------------------------------------
// debounce_chan
// One button channel: 2-flop synchroniser, stability counter, debounced level,
// press/release strobes, hold counter with long-press strobe, and (when
// DEBOUNCE_AUTO_REPEAT_EN is defined) an auto-repeat counter re-pulsing bas.
//
// Ports
//   clk       : system clock
//   reset     : synchronous, active-high reset
//   raw       : asynchronous input, 1 = pressed (polarity already applied)
//   temiz     : debounced level
//   bas       : one-cycle pulse on debounced 0->1 (and on auto-repeat)
//   birak     : one-cycle pulse on debounced 1->0
//   uzun_bas  : one-cycle pulse when the hold time reaches LONG_CYCLES
// -----------------------------------------------------------------------------
module debounce_chan
   import debounce_pkg::*;
#(
   parameter int STABLE_CYCLES = 50000,
   parameter int LONG_CYCLES   = 50000000,
   parameter int REPEAT_CYCLES = 10000000
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   output logic temiz,
   output logic bas,
   output logic birak,
   output logic uzun_bas
);

   localparam int SW = cnt_width(STABLE_CYCLES);
   // Hold counter must represent LONG_CYCLES itself: that is its parked value.
   localparam int HW = cnt_width(LONG_CYCLES + 1);

   localparam logic [SW-1:0] STABLE_LAST = SW'(STABLE_CYCLES - 1);
   localparam logic [HW-1:0] HOLD_LAST   = HW'(LONG_CYCLES - 1);
   localparam logic [HW-1:0] HOLD_SAT    = HW'(LONG_CYCLES);

   if (STABLE_CYCLES < 1) begin : g_bad_stable
      $error("debounce_chan: STABLE_CYCLES must be >= 1");
   end
   if (LONG_CYCLES < 1) begin : g_bad_long
      $error("debounce_chan: LONG_CYCLES must be >= 1");
   end
   if (REPEAT_CYCLES < 1) begin : g_bad_repeat
      $error("debounce_chan: REPEAT_CYCLES must be >= 1");
   end

   logic          sync0;
   logic          sync1;
   logic          cand;
   logic [SW-1:0] cnt;
   logic [HW-1:0] hold;
   logic          stab_done;
   logic          rise;
   logic          fall;
   logic          rep_fire;

   always_comb begin
      stab_done = (sync1 == cand) && (cnt == STABLE_LAST) && (temiz != cand);
      rise      = stab_done && cand;
      fall      = stab_done && !cand;
   end

`ifdef DEBOUNCE_AUTO_REPEAT_EN
   localparam int RW = cnt_width(REPEAT_CYCLES);
   localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);

   logic [RW-1:0] rep;
   logic          rep_run;

   // Repeat runs only once the hold counter has parked after uzun_bas.
   always_comb begin
      rep_run  = temiz && !fall && (hold == HOLD_SAT);
      rep_fire = rep_run && (rep == REP_LAST);
   end

   always_ff @(posedge clk) begin
      if (reset || !rep_run || rep == REP_LAST) begin
         rep <= '0;
      end else begin
         rep <= rep + 1'b1;
      end
   end
`else
   assign rep_fire = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         sync0    <= 1'b0;
         sync1    <= 1'b0;
         cand     <= 1'b0;
         cnt      <= '0;
         hold     <= '0;
         temiz    <= 1'b0;
         bas      <= 1'b0;
         birak    <= 1'b0;
         uzun_bas <= 1'b0;
      end else begin
         sync0 <= raw;
         sync1 <= sync0;

         if (sync1 != cand) begin
            cand <= sync1;
            cnt  <= '0;
         end else if (cnt < STABLE_LAST) begin
            cnt <= cnt + 1'b1;
         end

         if (stab_done) begin
            temiz <= cand;
         end

         if (!temiz) begin
            hold <= '0;
         end else if (hold < HOLD_SAT) begin
            hold <= hold + 1'b1;
         end

         bas   <= rise || rep_fire;
         birak <= fall;
         // A release landing on the threshold edge suppresses the long strobe.
         uzun_bas <= temiz && (hold == HOLD_LAST) && !fall;
      end
   end

endmodule

// File: rtl/debounce_multi.sv
// -----------------------------------------------------------------------------
// debounce_multi
// N-channel button conditioner. Each channel is an independent debounce_chan;
// ACTIVE_LOW inverts the raw inputs ahead of the synchronisers so everything
// downstream sees 1 = pressed.
// Optional build macro: DEBOUNCE_AUTO_REPEAT_EN (auto-repeat bas after a long
// press, period REPEAT_CYCLES).
//
// Ports
//   clk           : system clock
//   reset         : synchronous, active-high reset
//   buton         : [N_BTN] raw asynchronous mechanical inputs
//   temiz_sinyal  : [N_BTN] debounced level, 1 = pressed
//   bas           : [N_BTN] press strobe
//   birak         : [N_BTN] release strobe
//   uzun_bas      : [N_BTN] long-press strobe
// -----------------------------------------------------------------------------
module debounce_multi
   import debounce_pkg::*;
#(
   parameter int N_BTN         = 4,
   parameter int STABLE_CYCLES = 50000,
   parameter int LONG_CYCLES   = 50000000,
   parameter int REPEAT_CYCLES = 10000000,
   parameter bit ACTIVE_LOW    = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N_BTN-1:0] buton,
   output logic [N_BTN-1:0] temiz_sinyal,
   output logic [N_BTN-1:0] bas,
   output logic [N_BTN-1:0] birak,
   output logic [N_BTN-1:0] uzun_bas
);

   logic [N_BTN-1:0] raw;

   assign raw = ACTIVE_LOW ? ~buton : buton;

   for (genvar i = 0; i < N_BTN; i++) begin : g_chan
      debounce_chan #(
         .STABLE_CYCLES (STABLE_CYCLES),
         .LONG_CYCLES   (LONG_CYCLES),
         .REPEAT_CYCLES (REPEAT_CYCLES)
      ) u_chan (
         .clk      (clk),
         .reset    (reset),
         .raw      (raw[i]),
         .temiz    (temiz_sinyal[i]),
         .bas      (bas[i]),
         .birak    (birak[i]),
         .uzun_bas (uzun_bas[i])
      );
   end

endmodule

// File: tb/tb_debounce_multi.sv
// -----------------------------------------------------------------------------
// tb_debounce_multi
// Directed bench for debounce_multi with N_BTN=2, STABLE_CYCLES=8,
// LONG_CYCLES=20, REPEAT_CYCLES=5. A second instance is built ACTIVE_LOW=1.
// Expected timings: level/bas 11 edges after an input step, uzun_bas 20 edges
// after bas, auto-repeat bas every 5 edges after uzun_bas when enabled.
// -----------------------------------------------------------------------------
module tb_debounce_multi;

`ifdef DEBOUNCE_AUTO_REPEAT_EN
   localparam bit REP = 1'b1;
`else
   localparam bit REP = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [1:0] buton = 2'b00;
   logic [1:0] buton_n = 2'b11;
   logic [1:0] temiz_sinyal, bas, birak, uzun_bas;
   logic [1:0] temiz_n, bas_n, birak_n, uzun_n;
   logic       use_n = 1'b0;
   logic [1:0] ct, cb, cr, cu;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   debounce_multi #(
      .N_BTN(2), .STABLE_CYCLES(8), .LONG_CYCLES(20), .REPEAT_CYCLES(5),
      .ACTIVE_LOW(1'b0)
   ) dut (
      .clk(clk), .reset(reset), .buton(buton), .temiz_sinyal(temiz_sinyal),
      .bas(bas), .birak(birak), .uzun_bas(uzun_bas)
   );

   debounce_multi #(
      .N_BTN(2), .STABLE_CYCLES(8), .LONG_CYCLES(20), .REPEAT_CYCLES(5),
      .ACTIVE_LOW(1'b1)
   ) dut_n (
      .clk(clk), .reset(reset), .buton(buton_n), .temiz_sinyal(temiz_n),
      .bas(bas_n), .birak(birak_n), .uzun_bas(uzun_n)
   );

   always_comb begin
      ct = use_n ? temiz_n : temiz_sinyal;
      cb = use_n ? bas_n   : bas;
      cr = use_n ? birak_n : birak;
      cu = use_n ? uzun_n  : uzun_bas;
   end

   // Packed as {temiz, bas, birak, uzun_bas}, two bits each.
   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got t/b/r/u=%b want %b at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_edge(input string tag, input logic [1:0] t, input logic [1:0] b,
                              input logic [1:0] r, input logic [1:0] u);
      tick();
      check(tag, {ct, cb, cr, cu}, {t, b, r, u});
   endtask

   task automatic quiet(input string tag, input int n, input logic [1:0] t);
      for (int i = 0; i < n; i++) expect_edge(tag, t, 2'b00, 2'b00, 2'b00);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   logic [1:0] eb;

   initial begin
      // Reset state with idle inputs on both builds.
      repeat (3) tick();
      check("rst_state", {temiz_sinyal, bas, birak, uzun_bas}, 8'h00);
      check("rst_state_n", {temiz_n, bas_n, birak_n, uzun_n}, 8'h00);
      reset = 1'b0;
      quiet("idle", 4, 2'b00);

      // Clean step on channel 0, then reset with hold_cnt=10.
      buton = 2'b01;
      quiet("step_wait", 10, 2'b00);
      expect_edge("step_rise", 2'b01, 2'b01, 2'b00, 2'b00);
      quiet("step_hold", 10, 2'b01);
      reset = 1'b1;
      expect_edge("rst_mid", 2'b00, 2'b00, 2'b00, 2'b00);
      reset = 1'b0;
      quiet("rst_requal", 10, 2'b00);
      expect_edge("rst_rise", 2'b01, 2'b01, 2'b00, 2'b00);
      quiet("rst_after", 3, 2'b01);
      buton = 2'b00;
      do_reset();

      // Bounce: 3-cycle high/low for 40 cycles, then hold high.
      for (int i = 0; i < 40; i++) begin
         buton[0] = ((i / 3) % 2 == 0);
         expect_edge("bounce", 2'b00, 2'b00, 2'b00, 2'b00);
      end
      buton[0] = 1'b1;
      quiet("bounce_wait", 10, 2'b00);
      expect_edge("bounce_rise", 2'b01, 2'b01, 2'b00, 2'b00);
      buton = 2'b00;
      do_reset();

      // Long press on channel 1: bas at edge 11, uzun_bas at edge 31.
      buton = 2'b10;
      quiet("long_wait", 10, 2'b00);
      expect_edge("long_rise", 2'b10, 2'b10, 2'b00, 2'b00);
      for (int k = 12; k <= 71; k++) begin
         eb = (REP && k > 31 && (k - 31) % 5 == 0) ? 2'b10 : 2'b00;
         expect_edge("long_hold", 2'b10, eb, 2'b00, (k == 31) ? 2'b10 : 2'b00);
      end
      buton = 2'b00;
      for (int r = 1; r <= 10; r++) begin
         eb = (REP && (71 + r - 31) % 5 == 0) ? 2'b10 : 2'b00;
         expect_edge("long_rel_wait", 2'b10, eb, 2'b00, 2'b00);
      end
      expect_edge("long_fall", 2'b00, 2'b00, 2'b10, 2'b00);
      quiet("long_after", 3, 2'b00);
      do_reset();

      // Release lands on the long-press threshold edge: birak only.
      buton = 2'b10;
      quiet("race_wait", 10, 2'b00);
      expect_edge("race_rise", 2'b10, 2'b10, 2'b00, 2'b00);
      quiet("race_hold", 9, 2'b10);
      buton = 2'b00;
      quiet("race_rel_wait", 10, 2'b10);
      expect_edge("race_fall", 2'b00, 2'b00, 2'b10, 2'b00);
      quiet("race_after", 25, 2'b00);
      do_reset();

      // Simultaneous channels, then release only channel 0.
      buton = 2'b11;
      quiet("sim_wait", 10, 2'b00);
      expect_edge("sim_rise", 2'b11, 2'b11, 2'b00, 2'b00);
      buton = 2'b10;
      quiet("sim_rel_wait", 10, 2'b11);
      expect_edge("sim_fall0", 2'b10, 2'b00, 2'b01, 2'b00);
      buton = 2'b00;
      do_reset();

      // ACTIVE_LOW build: idle high, press by driving 0.
      use_n = 1'b1;
      quiet("al_idle", 4, 2'b00);
      buton_n = 2'b10;
      quiet("al_wait", 10, 2'b00);
      expect_edge("al_rise", 2'b01, 2'b01, 2'b00, 2'b00);
      buton_n = 2'b11;
      quiet("al_rel_wait", 10, 2'b01);
      expect_edge("al_fall", 2'b00, 2'b00, 2'b01, 2'b00);
      quiet("al_after", 3, 2'b00);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
